// File: rtl/ctrl_pkg.sv
// Shared encodings for the hardwired control unit: states, opcodes,
// instruction classes, enable/bus bit positions and ALU codes.
package ctrl_pkg;

  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_T0    = 4'd1,
    S_T1    = 4'd2,
    S_T2    = 4'd3,
    S_T3    = 4'd4,
    S_T4    = 4'd5,
    S_T5    = 4'd6,
    S_T6    = 4'd7,
    S_T7    = 4'd8,
    S_HALT  = 4'd9
  } state_t;

  typedef enum logic [3:0] {
    IC_LD, IC_LDI, IC_ST, IC_ALU, IC_ALUI, IC_BR, IC_JR,
    IC_IN, IC_OUT, IC_MFHI, IC_MFLO, IC_NOP, IC_HALT
  } iclass_t;

  localparam logic [4:0] OP_LD   = 5'd0;
  localparam logic [4:0] OP_LDI  = 5'd1;
  localparam logic [4:0] OP_ST   = 5'd2;
  localparam logic [4:0] OP_ADD  = 5'd3;
  localparam logic [4:0] OP_ROL  = 5'd11;
  localparam logic [4:0] OP_ADDI = 5'd12;
  localparam logic [4:0] OP_ANDI = 5'd13;
  localparam logic [4:0] OP_ORI  = 5'd14;
  localparam logic [4:0] OP_BR   = 5'd19;
  localparam logic [4:0] OP_JR   = 5'd20;
  localparam logic [4:0] OP_IN   = 5'd22;
  localparam logic [4:0] OP_OUT  = 5'd23;
  localparam logic [4:0] OP_MFHI = 5'd24;
  localparam logic [4:0] OP_MFLO = 5'd25;
  localparam logic [4:0] OP_NOP  = 5'd26;
  localparam logic [4:0] OP_HALT = 5'd27;

  localparam logic [4:0] CS_ALU_ADD = 5'd3;
  localparam logic [4:0] CS_ALU_AND = 5'd5;
  localparam logic [4:0] CS_ALU_OR  = 5'd6;
  localparam logic [4:0] CS_INCPC   = 5'd14;
  localparam logic [4:0] CS_ADD     = 5'd15;

  localparam int EN_HI  = 16;
  localparam int EN_LO  = 17;
  localparam int EN_Z   = 18;
  localparam int EN_Y   = 19;
  localparam int EN_PC  = 20;
  localparam int EN_MDR = 21;
  localparam int EN_IR  = 24;
  localparam int EN_MAR = 25;
  localparam int EN_OUT = 26;
  localparam int EN_CON = 27;

  localparam int BS_HI   = 16;
  localparam int BS_LO   = 17;
  localparam int BS_ZLO  = 19;
  localparam int BS_PC   = 20;
  localparam int BS_MDR  = 21;
  localparam int BS_IN   = 22;
  localparam int BS_C    = 23;

  // Final control step of each instruction class; fetch-only classes end at T2.
  function automatic state_t last_step(input iclass_t c);
    case (c)
      IC_LD, IC_ST:             last_step = S_T7;
      IC_BR:                    last_step = S_T6;
      IC_LDI, IC_ALU, IC_ALUI:  last_step = S_T5;
      IC_JR, IC_IN, IC_OUT,
      IC_MFHI, IC_MFLO:         last_step = S_T3;
      default:                  last_step = S_T2;
    endcase
  endfunction

  function automatic state_t succ(input state_t s);
    case (s)
      S_T0:    succ = S_T1;
      S_T1:    succ = S_T2;
      S_T2:    succ = S_T3;
      S_T3:    succ = S_T4;
      S_T4:    succ = S_T5;
      S_T5:    succ = S_T6;
      S_T6:    succ = S_T7;
      default: succ = S_T0;
    endcase
  endfunction

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decoder: instruction class plus the ALU code used
// during the operate step of register and immediate ALU instructions.
module instr_decode
  import ctrl_pkg::*;
(
  input  logic [4:0] opcode,
  output iclass_t    iclass,
  output logic [4:0] alu_code
);

  always_comb begin
    iclass   = IC_NOP;
    alu_code = 5'd0;
    case (opcode)
      OP_LD:   iclass = IC_LD;
      OP_LDI:  iclass = IC_LDI;
      OP_ST:   iclass = IC_ST;
      5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10, OP_ROL: begin
        iclass   = IC_ALU;
        alu_code = opcode;
      end
      OP_ADDI: begin
        iclass   = IC_ALUI;
        alu_code = CS_ALU_ADD;
      end
      OP_ANDI: begin
        iclass   = IC_ALUI;
        alu_code = CS_ALU_AND;
      end
      OP_ORI: begin
        iclass   = IC_ALUI;
        alu_code = CS_ALU_OR;
      end
      OP_BR:   iclass = IC_BR;
      OP_JR:   iclass = IC_JR;
      OP_IN:   iclass = IC_IN;
      OP_OUT:  iclass = IC_OUT;
      OP_MFHI: iclass = IC_MFHI;
      OP_MFLO: iclass = IC_MFLO;
      OP_HALT: iclass = IC_HALT;
      default: iclass = IC_NOP;
    endcase
  end

endmodule

// File: rtl/control_unit.sv
// Hardwired multi-cycle control unit: one control step per clock, outputs
// decoded from the registered step and the current opcode.
module control_unit
  import ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] ir,
  input  logic        CONFFOut,
  output logic [31:0] enable,
  output logic [31:0] busSelect,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic        MD_Read,
  output logic        ReadRAM,
  output logic        WriteRAM,
  output logic [4:0]  Control_Signals,
  output logic        instr_done,
  output logic        halted
);

  state_t      state, state_next;
  iclass_t     cls;
  logic [4:0]  alu_code;
  logic [26:0] unused_ir_bits;

  assign unused_ir_bits = ir[26:0];

  instr_decode u_decode (
    .opcode   (ir[31:27]),
    .iclass   (cls),
    .alu_code (alu_code)
  );

  always_ff @(posedge clk) begin
    if (!clr) state <= S_RESET;
    else      state <= state_next;
  end

  always_comb begin
    case (state)
      S_RESET: state_next = S_T0;
      S_HALT:  state_next = S_HALT;
      default: begin
        if (state == last_step(cls))
          state_next = (cls == IC_HALT) ? S_HALT : S_T0;
        else
          state_next = succ(state);
      end
    endcase
  end

  always_comb begin
    enable          = '0;
    busSelect       = '0;
    Gra             = 1'b0;
    Grb             = 1'b0;
    Grc             = 1'b0;
    Rin             = 1'b0;
    Rout            = 1'b0;
    BAout           = 1'b0;
    MD_Read         = 1'b0;
    ReadRAM         = 1'b0;
    WriteRAM        = 1'b0;
    Control_Signals = '0;
    instr_done      = (state == last_step(cls));
    halted          = (state == S_HALT);
    case (state)
      S_T0: begin
        busSelect[BS_PC] = 1'b1;
        enable[EN_MAR]   = 1'b1;
        enable[EN_Z]     = 1'b1;
        Control_Signals  = CS_INCPC;
      end
      S_T1: begin
        busSelect[BS_ZLO] = 1'b1;
        enable[EN_PC]     = 1'b1;
        enable[EN_MDR]    = 1'b1;
        MD_Read           = 1'b1;
        ReadRAM           = 1'b1;
      end
      S_T2: begin
        busSelect[BS_MDR] = 1'b1;
        enable[EN_IR]     = 1'b1;
      end
      S_T3: begin
        case (cls)
          IC_LD, IC_LDI, IC_ST: begin
            Grb = 1'b1; BAout = 1'b1; enable[EN_Y] = 1'b1;
          end
          IC_ALU, IC_ALUI: begin
            Grb = 1'b1; Rout = 1'b1; enable[EN_Y] = 1'b1;
          end
          IC_BR:   begin Gra = 1'b1; Rout = 1'b1; enable[EN_CON] = 1'b1; end
          IC_JR:   begin Gra = 1'b1; Rout = 1'b1; enable[EN_PC] = 1'b1; end
          IC_IN:   begin busSelect[BS_IN] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          IC_OUT:  begin Gra = 1'b1; Rout = 1'b1; enable[EN_OUT] = 1'b1; end
          IC_MFHI: begin busSelect[BS_HI] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          IC_MFLO: begin busSelect[BS_LO] = 1'b1; Gra = 1'b1; Rin = 1'b1; end
          default: ;
        endcase
      end
      S_T4: begin
        case (cls)
          IC_LD, IC_LDI, IC_ST: begin
            busSelect[BS_C] = 1'b1; Control_Signals = CS_ADD; enable[EN_Z] = 1'b1;
          end
          IC_ALU: begin
            Grc = 1'b1; Rout = 1'b1; Control_Signals = alu_code; enable[EN_Z] = 1'b1;
          end
          IC_ALUI: begin
            busSelect[BS_C] = 1'b1; Control_Signals = alu_code; enable[EN_Z] = 1'b1;
          end
          IC_BR: begin
            busSelect[BS_PC] = 1'b1; enable[EN_Y] = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        case (cls)
          IC_LD, IC_ST: begin
            busSelect[BS_ZLO] = 1'b1; enable[EN_MAR] = 1'b1;
          end
          IC_LDI, IC_ALU, IC_ALUI: begin
            busSelect[BS_ZLO] = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          IC_BR: begin
            busSelect[BS_C] = 1'b1; Control_Signals = CS_ADD; enable[EN_Z] = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        case (cls)
          IC_LD: begin
            MD_Read = 1'b1; ReadRAM = 1'b1; enable[EN_MDR] = 1'b1;
          end
          // Store data comes from the register file, so MDR takes the bus.
          IC_ST: begin
            Gra = 1'b1; Rout = 1'b1; enable[EN_MDR] = 1'b1;
          end
          IC_BR: begin
            if (CONFFOut) begin
              busSelect[BS_ZLO] = 1'b1; enable[EN_PC] = 1'b1;
            end
          end
          default: ;
        endcase
      end
      S_T7: begin
        case (cls)
          IC_LD: begin
            busSelect[BS_MDR] = 1'b1; Gra = 1'b1; Rin = 1'b1;
          end
          IC_ST:   WriteRAM = 1'b1;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_unit.sv
// Directed bench for control_unit: step-by-step output vectors for fetch,
// branch, load/store, ALU, halt and reset sequences.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] ir;
  logic        CONFFOut;
  logic [31:0] enable, busSelect;
  logic        Gra, Grb, Grc, Rin, Rout, BAout, MD_Read, ReadRAM, WriteRAM;
  logic [4:0]  Control_Signals;
  logic        instr_done, halted;

  int tests = 0;
  int fails = 0;

  control_unit dut (
    .clk             (clk),
    .clr             (clr),
    .ir              (ir),
    .CONFFOut        (CONFFOut),
    .enable          (enable),
    .busSelect       (busSelect),
    .Gra             (Gra),
    .Grb             (Grb),
    .Grc             (Grc),
    .Rin             (Rin),
    .Rout            (Rout),
    .BAout           (BAout),
    .MD_Read         (MD_Read),
    .ReadRAM         (ReadRAM),
    .WriteRAM        (WriteRAM),
    .Control_Signals (Control_Signals),
    .instr_done      (instr_done),
    .halted          (halted)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] E_Z   = 32'h0004_0000;
  localparam logic [31:0] E_Y   = 32'h0008_0000;
  localparam logic [31:0] E_PC  = 32'h0010_0000;
  localparam logic [31:0] E_MDR = 32'h0020_0000;
  localparam logic [31:0] E_IR  = 32'h0100_0000;
  localparam logic [31:0] E_MAR = 32'h0200_0000;
  localparam logic [31:0] E_CON = 32'h0800_0000;

  localparam logic [31:0] B_LO  = 32'h0002_0000;
  localparam logic [31:0] B_ZLO = 32'h0008_0000;
  localparam logic [31:0] B_PC  = 32'h0010_0000;
  localparam logic [31:0] B_MDR = 32'h0020_0000;
  localparam logic [31:0] B_C   = 32'h0080_0000;

  // Flag order: Gra Grb Grc Rin Rout BAout MD_Read ReadRAM WriteRAM
  localparam logic [8:0] F_GRA  = 9'h100;
  localparam logic [8:0] F_GRB  = 9'h080;
  localparam logic [8:0] F_GRC  = 9'h040;
  localparam logic [8:0] F_RIN  = 9'h020;
  localparam logic [8:0] F_ROUT = 9'h010;
  localparam logic [8:0] F_BA   = 9'h008;
  localparam logic [8:0] F_MDRD = 9'h004;
  localparam logic [8:0] F_RD   = 9'h002;
  localparam logic [8:0] F_WR   = 9'h001;

  localparam logic [79:0] ZERO = 80'h0;

  function automatic logic [79:0] mk(input logic [31:0] en, input logic [31:0] bs,
                                     input logic [8:0] fl, input logic [4:0] cs,
                                     input logic done, input logic hlt);
    mk = {en, bs, fl, cs, done, hlt};
  endfunction

  function automatic logic [79:0] snap();
    snap = {enable, busSelect, Gra, Grb, Grc, Rin, Rout, BAout, MD_Read, ReadRAM,
            WriteRAM, Control_Signals, instr_done, halted};
  endfunction

  task automatic check(input string tag, input logic [79:0] exp);
    logic [79:0] obs;
    obs = snap();
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called while in T0; loads the next instruction and walks the fetch steps.
  task automatic fetch(input logic [31:0] instr, input logic t2_done, input string tag);
    ir = instr;
    check({tag, "_T0"}, mk(E_MAR | E_Z, B_PC, 9'h0, 5'd14, 1'b0, 1'b0));
    tick();
    check({tag, "_T1"}, mk(E_PC | E_MDR, B_ZLO, F_MDRD | F_RD, 5'd0, 1'b0, 1'b0));
    tick();
    check({tag, "_T2"}, mk(E_IR, B_MDR, 9'h0, 5'd0, t2_done, 1'b0));
  endtask

  initial begin
    clr = 1'b0;
    ir = 32'h0;
    CONFFOut = 1'b0;

    // Reset held for three edges
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_hold", ZERO);
    end
    clr = 1'b1;
    tick();

    // Branch, condition true
    CONFFOut = 1'b1;
    fetch(32'h9800_0004, 1'b0, "br_t");
    tick(); check("br_t_T3", mk(E_CON, 32'h0, F_GRA | F_ROUT, 5'd0, 1'b0, 1'b0));
    tick(); check("br_t_T4", mk(E_Y, B_PC, 9'h0, 5'd0, 1'b0, 1'b0));
    tick(); check("br_t_T5", mk(E_Z, B_C, 9'h0, 5'd15, 1'b0, 1'b0));
    tick(); check("br_t_T6", mk(E_PC, B_ZLO, 9'h0, 5'd0, 1'b1, 1'b0));
    tick();

    // Branch, condition false: T6 only signals completion
    CONFFOut = 1'b0;
    fetch(32'h9800_0004, 1'b0, "br_f");
    tick(); check("br_f_T3", mk(E_CON, 32'h0, F_GRA | F_ROUT, 5'd0, 1'b0, 1'b0));
    tick(); check("br_f_T4", mk(E_Y, B_PC, 9'h0, 5'd0, 1'b0, 1'b0));
    tick(); check("br_f_T5", mk(E_Z, B_C, 9'h0, 5'd15, 1'b0, 1'b0));
    tick(); check("br_f_T6", mk(32'h0, 32'h0, 9'h0, 5'd0, 1'b1, 1'b0));
    tick();

    // ld
    fetch(32'h0000_0055, 1'b0, "ld");
    tick(); check("ld_T3", mk(E_Y, 32'h0, F_GRB | F_BA, 5'd0, 1'b0, 1'b0));
    tick(); check("ld_T4", mk(E_Z, B_C, 9'h0, 5'd15, 1'b0, 1'b0));
    tick(); check("ld_T5", mk(E_MAR, B_ZLO, 9'h0, 5'd0, 1'b0, 1'b0));
    tick(); check("ld_T6", mk(E_MDR, 32'h0, F_MDRD | F_RD, 5'd0, 1'b0, 1'b0));
    tick(); check("ld_T7", mk(32'h0, B_MDR, F_GRA | F_RIN, 5'd0, 1'b1, 1'b0));
    tick();

    // st
    fetch(32'h1000_0055, 1'b0, "st");
    tick(); check("st_T3", mk(E_Y, 32'h0, F_GRB | F_BA, 5'd0, 1'b0, 1'b0));
    tick(); check("st_T4", mk(E_Z, B_C, 9'h0, 5'd15, 1'b0, 1'b0));
    tick(); check("st_T5", mk(E_MAR, B_ZLO, 9'h0, 5'd0, 1'b0, 1'b0));
    tick(); check("st_T6", mk(E_MDR, 32'h0, F_GRA | F_ROUT, 5'd0, 1'b0, 1'b0));
    tick(); check("st_T7", mk(32'h0, 32'h0, F_WR, 5'd0, 1'b1, 1'b0));
    tick();

    // sub (opcode 4)
    fetch(32'h2000_0000, 1'b0, "sub");
    tick(); check("sub_T3", mk(E_Y, 32'h0, F_GRB | F_ROUT, 5'd0, 1'b0, 1'b0));
    tick(); check("sub_T4", mk(E_Z, 32'h0, F_GRC | F_ROUT, 5'd4, 1'b0, 1'b0));
    tick(); check("sub_T5", mk(32'h0, B_ZLO, F_GRA | F_RIN, 5'd0, 1'b1, 1'b0));
    tick();

    // andi (opcode 13) uses ALU code 5 with the constant on the bus
    fetch(32'h6800_0000, 1'b0, "andi");
    tick(); check("andi_T3", mk(E_Y, 32'h0, F_GRB | F_ROUT, 5'd0, 1'b0, 1'b0));
    tick(); check("andi_T4", mk(E_Z, B_C, 9'h0, 5'd5, 1'b0, 1'b0));
    tick(); check("andi_T5", mk(32'h0, B_ZLO, F_GRA | F_RIN, 5'd0, 1'b1, 1'b0));
    tick();

    // ldi (opcode 1): address add, then result to Ra
    fetch(32'h0800_0000, 1'b0, "ldi");
    tick(); check("ldi_T3", mk(E_Y, 32'h0, F_GRB | F_BA, 5'd0, 1'b0, 1'b0));
    tick(); check("ldi_T4", mk(E_Z, B_C, 9'h0, 5'd15, 1'b0, 1'b0));
    tick(); check("ldi_T5", mk(32'h0, B_ZLO, F_GRA | F_RIN, 5'd0, 1'b1, 1'b0));
    tick();

    // mflo (opcode 25), jr (opcode 20): single execute step
    fetch(32'hC800_0000, 1'b0, "mflo");
    tick(); check("mflo_T3", mk(32'h0, B_LO, F_GRA | F_RIN, 5'd0, 1'b1, 1'b0));
    tick();
    fetch(32'hA000_0000, 1'b0, "jr");
    tick(); check("jr_T3", mk(E_PC, 32'h0, F_GRA | F_ROUT, 5'd0, 1'b1, 1'b0));
    tick();

    // Undefined opcode 31 behaves as nop
    fetch(32'hF800_0000, 1'b1, "op31");
    tick();

    // halt
    fetch(32'hD800_0000, 1'b1, "halt");
    for (int i = 0; i < 20; i++) begin
      tick();
      check("halt_hold", mk(32'h0, 32'h0, 9'h0, 5'd0, 1'b0, 1'b1));
    end
    clr = 1'b0;
    tick(); check("halt_reset", ZERO);
    clr = 1'b1;
    tick();

    // Reset in the middle of ld T5 must suppress the T7 register write
    fetch(32'h0000_0055, 1'b0, "ldrst");
    tick(); tick(); tick();
    check("ldrst_T5", mk(E_MAR, B_ZLO, 9'h0, 5'd0, 1'b0, 1'b0));
    clr = 1'b0;
    tick(); check("ldrst_reset", ZERO);
    clr = 1'b1;
    tick(); check("ldrst_T0", mk(E_MAR | E_Z, B_PC, 9'h0, 5'd14, 1'b0, 1'b0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
